// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Fetch-stage bus: decoder handshake, redirect, BIOS/IMEM ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int BIOS_AWIDTH = 12,
  parameter int IMEM_AWIDTH = 14
);
  logic                   stall;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [BIOS_AWIDTH-1:0] bios_addr;
  logic [31:0]            bios_dout;
  logic [IMEM_AWIDTH-1:0] imem_addr;
  logic [31:0]            imem_dout;
  logic [31:0]            instr;
  logic [31:0]            instr_pc;
  logic                   instr_valid;
  logic                   misalign_err;
  logic [31:0]            fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, bios_dout, imem_dout,
    output bios_addr, imem_addr, instr, instr_pc, instr_valid,
           misalign_err, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, bios_dout, imem_dout,
    input  bios_addr, imem_addr, instr, instr_pc, instr_valid,
           misalign_err, fetch_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : PC owner; fetches from BIOS/IMEM and feeds the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter int          BIOS_AWIDTH = 12,
  parameter int          IMEM_AWIDTH = 14,
  parameter logic [31:0] NOP         = 32'h0000_0013
) (
  input  wire            clk,
  input  wire            rst,
  instr_fetch_if.master  bus
);
  localparam logic [31:0] C_PC_PRE_RESET = RESET_PC - 32'd4;

  logic [31:0] req_pc;
  logic [31:0] pc_q;
  logic        valid_q, valid_d;
  logic        sel_bios_q;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic        instr_valid;

  always_comb begin
    req_pc = pc_q + 32'd4;
    if (rst)               req_pc = RESET_PC;
    else if (bus.redirect) req_pc = {bus.redirect_pc[31:2], 2'b00};
    else if (bus.stall)    req_pc = pc_q;
  end

  // A redirect kills the wrong-path word presented in the same cycle.
  assign instr_valid = valid_q & ~bus.redirect & ~rst;

  always_comb begin
    valid_d = 1'b1;
    if (bus.stall && !bus.redirect) valid_d = valid_q;
    err_d = err_q | (bus.redirect & (|bus.redirect_pc[1:0]));
    cnt_d = cnt_q + {31'd0, instr_valid & ~bus.stall};
  end

  always_ff @(posedge clk) begin
    sel_bios_q <= req_pc[30];
    if (rst) begin
      pc_q    <= C_PC_PRE_RESET;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= req_pc;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.bios_addr    = req_pc[BIOS_AWIDTH+1:2];
  assign bus.imem_addr    = req_pc[IMEM_AWIDTH+1:2];
  assign bus.instr_valid  = instr_valid;
  assign bus.instr        = instr_valid ? (sel_bios_q ? bus.bios_dout
                                                      : bus.imem_dout)
                                        : NOP;
  assign bus.instr_pc     = pc_q;
  assign bus.misalign_err = err_q;
  assign bus.fetch_count  = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Randomized scoreboard bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.BIOS_AWIDTH(12), .IMEM_AWIDTH(14)) fif ();

  instr_fetch #(
    .RESET_PC(RESET_PC), .BIOS_AWIDTH(12), .IMEM_AWIDTH(14), .NOP(NOP)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(fif)
  );

  function automatic logic [31:0] bios_word(input logic [11:0] a);
    return {8'hB1, 12'h000, a} ^ {a, 20'h5A5A5};
  endfunction

  function automatic logic [31:0] imem_word(input logic [13:0] a);
    return {8'h1E, 10'h000, a} ^ {a, 18'h2C3C3};
  endfunction

  // Instruction stored at a byte address: bit 30 selects BIOS over IMEM.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [11:0] ba;
    logic [13:0] ia;
    ba = pc[13:2];
    ia = pc[15:2];
    return pc[30] ? bios_word(ba) : imem_word(ia);
  endfunction

  always @(posedge clk) begin
    fif.bios_dout <= bios_word(fif.bios_addr);
    fif.imem_dout <= imem_word(fif.imem_addr);
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [11:0] ba;
    logic [13:0] ia;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference view: which PC is at the decoder and whether it is live.
  logic [31:0] m_pc;
  logic        m_live;
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] rp);
    exp_t        e;
    logic        v;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    rst = r;
    fif.stall = s;
    fif.redirect = rd;
    fif.redirect_pc = rp;
    v = m_live && !rd && !r;
    if (r)       nxt = RESET_PC;
    else if (rd) nxt = {rp[31:2], 2'b00};
    else if (s)  nxt = m_pc;
    else         nxt = m_pc + 32'd4;
    e.valid = v;
    e.instr = v ? word_at(m_pc) : NOP;
    e.pc    = m_pc;
    e.ba    = nxt[13:2];
    e.ia    = nxt[15:2];
    e.err   = m_err;
    e.cnt   = m_cnt;
    sb.push_back(e);
    if (r) begin
      m_pc   = RESET_PC - 32'd4;
      m_live = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 32'd0;
    end else begin
      if (v && !s) m_cnt = m_cnt + 32'd1;
      if (rd && rp[1:0] != 2'b00) m_err = 1'b1;
      if (rd || !s) m_live = 1'b1;
      m_pc = nxt;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("instr_valid", {31'd0, fif.instr_valid}, {31'd0, e.valid});
        chk("instr", fif.instr, e.instr);
        chk("instr_pc", fif.instr_pc, e.pc);
        chk("bios_addr", {20'd0, fif.bios_addr}, {20'd0, e.ba});
        chk("imem_addr", {18'd0, fif.imem_addr}, {18'd0, e.ia});
        chk("misalign_err", {31'd0, fif.misalign_err}, {31'd0, e.err});
        chk("fetch_count", fif.fetch_count, e.cnt);
      end
    end
  end

  initial begin : driver
    logic [31:0] rp;
    rst = 1'b1;
    fif.stall = 1'b0;
    fif.redirect = 1'b0;
    fif.redirect_pc = 32'd0;
    m_pc = RESET_PC - 32'd4;
    m_live = 1'b0;
    m_err = 1'b0;
    m_cnt = 32'd0;
    @(posedge clk);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h1000_0020);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h4000_0100);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h1000_0006);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h1234_5678);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFF8);
    repeat (4) step(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) rp = 32'hFFFF_FFF8;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, rp);
    end
    repeat (3) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage sitting directly upstream of the instruction decoder; owns the PC and drives the 32-bit instruction word the decoder turns into a control-ROM index.
- Issues word addresses to BIOS and IMEM synchronous-read memories (1-cycle read latency) and selects the returning word.
- Honours stall from downstream and PC redirect from branch/jump resolution.
- Kills the wrong-path instruction with a NOP bubble and keeps a delivered-instruction counter.

Parameters:
- RESET_PC, 32'h4000_0000, first fetched address after reset (BIOS base).
- BIOS_AWIDTH, 12, BIOS word-address width.
- IMEM_AWIDTH, 14, IMEM word-address width.
- NOP, 32'h0000_0013, word driven when no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decoder cannot accept; hold current instruction.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  target address; valid only when redirect=1.
- bios_addr  out  BIOS_AWIDTH  BIOS word address (combinational).
- bios_dout  in  32  BIOS read data, one cycle after address.
- imem_addr  out  IMEM_AWIDTH  IMEM word address (combinational).
- imem_dout  in  32  IMEM read data, one cycle after address.
- instr  out  32  instruction to decoder.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr is a real, live instruction.
- misalign_err  out  1  sticky: redirect_pc[1:0] was nonzero.
- fetch_count  out  32  count of delivered instructions.

Behaviour:
- Only clk and rst exist: one clock, synchronous active-high reset. No async logic.
- Registers:
  - pc_q: address presented in the previous cycle, i.e. the address whose data is on *_dout now.
  - valid_q, sel_bios_q (= pc_q[30]), err_q, cnt_q.
- Next-address mux (combinational req_pc), priority order:
  - rst -> RESET_PC
  - redirect -> {redirect_pc[31:2],2'b00}
  - stall -> pc_q
  - else pc_q + 4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- Address outputs:
  - bios_addr = req_pc[BIOS_AWIDTH+1:2]; imem_addr = req_pc[IMEM_AWIDTH+1:2].
  - Both driven every cycle; the unused memory's data is ignored.
- On every edge: pc_q <= req_pc and sel_bios_q <= req_pc[30].
- Reset:
  - pc_q <= RESET_PC - 4, valid_q <= 0, err_q <= 0, cnt_q <= 0.
  - During rst, outputs read as instr=NOP, instr_valid=0, instr_pc=pc_q.
- First cycle after rst deasserts: valid_q=0, req_pc=RESET_PC. The following cycle instr is the word at RESET_PC with instr_valid=1, giving 1 bubble.
- valid_q next value:
  - rst -> 0
  - redirect -> 1, since target data arrives next cycle.
  - stall -> valid_q (hold)
  - else 1.
- Outputs:
  - instr_valid = valid_q & ~redirect. A redirect combinationally kills the instruction currently presented, which is wrong-path.
  - instr = instr_valid ? (sel_bios_q ? bios_dout : imem_dout) : NOP.
  - instr_pc = pc_q.
- Stall: the same address is re-presented, so *_dout, instr and instr_pc stay stable across any stall length.
- Redirect and stall in the same cycle: redirect wins. The stalled instruction is killed and the target is fetched.
- Redirect latency: the target instruction is at the decoder 1 cycle after the redirect cycle. Exactly one killed slot (the redirect cycle) per redirect.
- misalign_err: err_q <= err_q | (redirect & |redirect_pc[1:0]). Cleared only by rst. The PC is still aligned by zeroing bits [1:0].
- fetch_count:
  - cnt_q increments by 1 on each edge where instr_valid & ~stall & ~rst; wraps at 2^32.
  - Redirect-killed slots are not counted.
- rst mid-stall or mid-redirect: rst dominates all; state becomes as above on the same edge.

Test Plan:
- Reset release, no stall, BIOS words W0..W3 at 0x4000_0000..C -> cycle1 instr=NOP, valid=0, bios_addr=0; cycles 2-5 instr=W0..W3, instr_pc=0x4000_0000..0x4000_000C, valid=1; fetch_count=4.
- Stall held 3 cycles while instr=W1 (pc 0x4000_0004) -> instr, instr_pc and bios_addr (=1) constant for 3 cycles; fetch_count unchanged during stall, +1 on release; W2 follows.
- redirect=1, redirect_pc=0x1000_0020 while instr=W2 -> that cycle instr=NOP, valid=0, imem_addr=8; next cycle instr=imem word 8, instr_pc=0x1000_0020, sel from IMEM.
- redirect and stall asserted together, redirect_pc=0x4000_0100 -> redirect wins, bios_addr=0x40; next cycle instr_pc=0x4000_0100, valid=1.
- redirect_pc=0x1000_0006 -> next instr_pc=0x1000_0004, misalign_err=1 and stays 1 until rst; rst then clears it and fetch_count=0.
- rst asserted mid-run for 1 cycle -> next cycle instr=NOP, valid=0, pc restarts at RESET_PC; PC wrap from 0xFFFF_FFFC goes to 0x0000_0000.
